// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - four-way memory port arbiter with fetch anti-starvation and access timeout
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int TIMEOUT    = 15,
    parameter int STARVE_LIM = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req,
    input  logic [3:0]            req_we,
    input  logic [3:0]            req_byte,
    input  logic [4*ADDR_W-1:0]   req_addr,
    input  logic [4*DATA_W-1:0]   req_wdata,
    output logic [3:0]            grant,
    output logic [3:0]            done,
    output logic [3:0]            err,
    output logic [DATA_W-1:0]     rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic                  mem_byte,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic                  busy,
    output logic [1:0]            arb_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_RESP   = 2'b10
    } state_t;

    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);
    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIM);

    state_t              state, state_nxt;
    logic [1:0]          idx;
    logic [ADDR_W-1:0]   l_addr;
    logic [DATA_W-1:0]   l_wdata;
    logic                l_we;
    logic                l_byte;
    logic                l_err;
    logic [7:0]          to_cnt;
    logic [7:0]          starve_cnt;
    logic [DATA_W-1:0]   rdata_q;

    logic [1:0]          win_idx;
    logic [ADDR_W-1:0]   win_addr;
    logic                win_misaligned;
    logic [DATA_W-1:0]   rd_fmt;
    logic [3:0]          grant_v;

    // Winner selection: fixed priority 0 > 1 > 2 > 3 unless fetch has starved long enough
    always_comb begin
        win_idx = 2'd3;
        if (req[3] && starve_cnt == STARVE_MAX)
            win_idx = 2'd3;
        else if (req[0])
            win_idx = 2'd0;
        else if (req[1])
            win_idx = 2'd1;
        else if (req[2])
            win_idx = 2'd2;
        win_addr       = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
        win_misaligned = !req_byte[win_idx] && win_addr[0];
    end

    // Lane extraction for byte reads; word reads pass straight through
    always_comb begin
        rd_fmt = mem_rdata;
        if (l_byte)
            rd_fmt = l_addr[0] ? {8'h00, mem_rdata[15:8]} : {8'h00, mem_rdata[7:0]};
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic: misaligned word accesses skip memory entirely
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (|req) state_nxt = win_misaligned ? S_RESP : S_ACCESS;
            S_ACCESS: if (mem_ack || to_cnt == TO_LAST) state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Request latch, timeout/starve counters and read-data capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx        <= 2'd0;
            l_addr     <= '0;
            l_wdata    <= '0;
            l_we       <= 1'b0;
            l_byte     <= 1'b0;
            l_err      <= 1'b0;
            to_cnt     <= 8'd0;
            starve_cnt <= 8'd0;
            rdata_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        idx     <= win_idx;
                        l_addr  <= win_addr;
                        l_wdata <= req_wdata[int'(win_idx)*DATA_W +: DATA_W];
                        l_we    <= req_we[win_idx];
                        l_byte  <= req_byte[win_idx];
                        l_err   <= win_misaligned;
                        to_cnt  <= 8'd0;
                        if (win_misaligned)
                            rdata_q <= '0;
                        if (win_idx == 2'd3 || !req[3])
                            starve_cnt <= 8'd0;
                        else if (starve_cnt != STARVE_MAX)
                            starve_cnt <= starve_cnt + 8'd1;
                    end
                end
                S_ACCESS: begin
                    if (mem_ack) begin
                        rdata_q <= l_we ? '0 : rd_fmt;
                        l_err   <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                        if (to_cnt == TO_LAST) begin
                            l_err   <= 1'b1;
                            rdata_q <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from the registered state and latched request
    always_comb begin
        grant_v   = (state != S_IDLE) ? (4'b0001 << idx) : 4'b0000;
        grant     = grant_v;
        done      = (state == S_RESP && !l_err) ? grant_v : 4'b0000;
        err       = (state == S_RESP &&  l_err) ? grant_v : 4'b0000;
        rdata     = rdata_q;
        mem_en    = (state == S_ACCESS);
        mem_we    = mem_en & l_we;
        mem_byte  = mem_en & l_byte;
        mem_addr  = mem_en ? l_addr : '0;
        mem_wdata = '0;
        if (mem_en)
            mem_wdata = l_byte ? {l_wdata[7:0], l_wdata[7:0]} : l_wdata;
        busy      = (state != S_IDLE);
        arb_state = state;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int TIMEOUT    = 15;
    localparam int STARVE_LIM = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0, req_we = '0, req_byte = '0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  grant, done, err;
    logic [15:0] rdata, mem_addr, mem_wdata;
    logic        mem_en, mem_we, mem_byte, busy;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [1:0]  arb_state;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int starve     = 0;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TIMEOUT), .STARVE_LIM(STARVE_LIM)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_byte(req_byte),
        .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant), .done(done), .err(err),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_byte(mem_byte),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .arb_state(arb_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference arbitration: which requester wins, and how long fetch has been waiting
    function automatic int pick_winner(input logic [3:0] rv);
        if (rv[3] && starve == STARVE_LIM) return 3;
        for (int i = 0; i < 4; i++) if (rv[i]) return i;
        return 3;
    endfunction

    // One arbitration round; caller is at #1 after a clock edge with the DUT in IDLE
    task automatic do_access(input logic [3:0] rv, input logic [3:0] we_v, input logic [3:0] by_v,
                             input logic [63:0] addr_v, input logic [63:0] wd_v,
                             input int ack_dly, input logic [15:0] mrd);
        int w, c, n_en;
        logic [15:0] a, wd, exp_rd, exp_wd;
        logic mis, ok;
        req = rv; req_we = we_v; req_byte = by_v; req_addr = addr_v; req_wdata = wd_v;
        mem_rdata = mrd; mem_ack = 1'b0;
        if (rv == 4'b0000) begin
            @(posedge clk); #1;
            check("idle_hold", {30'd0, arb_state}, 32'd0);
            return;
        end
        w = pick_winner(rv);
        if (w == 3 || !rv[3]) starve = 0;
        else if (starve < STARVE_LIM) starve++;
        a   = addr_v[w*16 +: 16];
        wd  = wd_v[w*16 +: 16];
        mis = !by_v[w] && a[0];
        @(posedge clk); #1;
        check("grant", {28'd0, grant}, 32'd1 << w);
        if (mis) begin
            check("mis_state", {30'd0, arb_state}, 32'd2);
            check("mis_en", {31'd0, mem_en}, 32'd0);
            check("mis_err", {28'd0, err}, 32'd1 << w);
            check("mis_done", {28'd0, done}, 32'd0);
            @(posedge clk); #1;
            check("mis_idle", {27'd0, busy, grant}, 32'd0);
            return;
        end
        ok     = ack_dly < TIMEOUT;
        n_en   = ok ? ack_dly + 1 : TIMEOUT;
        exp_wd = by_v[w] ? {wd[7:0], wd[7:0]} : wd;
        exp_rd = !ok || we_v[w] ? 16'h0 : (!by_v[w] ? mrd : (a[0] ? {8'h00, mrd[15:8]} : {8'h00, mrd[7:0]}));
        check("acc_state", {30'd0, arb_state}, 32'd1);
        check("acc_port", {13'd0, mem_en, mem_we, mem_byte, mem_addr},
              {13'd0, 1'b1, we_v[w], by_v[w], a});
        check("acc_wdata", {16'd0, mem_wdata}, {16'd0, exp_wd});
        c = 0;
        while (arb_state == 2'd1 && c < 64) begin
            if (mem_en !== 1'b1 || mem_addr !== a) check("acc_stable", {15'd0, mem_en, mem_addr}, {15'd0, 1'b1, a});
            mem_ack = (c == ack_dly);
            @(posedge clk); #1;
            mem_ack = 1'b0;
            c++;
        end
        check("en_cycles", c, n_en);
        check("resp_state", {29'd0, mem_en, arb_state}, 32'd2);
        check("resp_done", {28'd0, done}, ok ? (32'd1 << w) : 32'd0);
        check("resp_err", {28'd0, err}, ok ? 32'd0 : (32'd1 << w));
        if (ok) check("resp_rdata", {16'd0, rdata}, {16'd0, exp_rd});
        @(posedge clk); #1;
        check("back_idle", {25'd0, busy, arb_state, grant, mem_en}, 32'd0);
    endtask

    initial begin
        logic [63:0] ra, rw;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", {grant, done, err, mem_en, mem_we, mem_byte, busy, arb_state}, 32'd0);
        check("rst_bus", {mem_addr, mem_wdata}, 32'd0);
        check("rst_rdata", {16'd0, rdata}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // src read, immediate ack
        do_access(4'b0100, 4'b0000, 4'b0000, 64'h0000_0200_0000_0000, 64'h0, 0, 16'hBEEF);
        // all four held: 0,0,0, fetch forced, 0
        for (int i = 0; i < 5; i++)
            do_access(4'b1111, 4'b0000, 4'b0000, 64'h1000_2000_3000_4000, 64'h0, 0, 16'h1234 + 16'(i));
        // byte read at odd address, then misaligned word write
        do_access(4'b0010, 4'b0000, 4'b0010, 64'h0000_0000_0301_0000, 64'h0, 1, 16'h12AB);
        do_access(4'b0001, 4'b0001, 4'b0000, 64'h0000_0000_0000_0301, 64'h5555, 0, 16'h0);
        // timeout, then ack on the last allowed cycle
        do_access(4'b0100, 4'b0000, 4'b0000, 64'h0000_0500_0000_0000, 64'h0, 1000, 16'hAAAA);
        do_access(4'b0100, 4'b0000, 4'b0000, 64'h0000_0502_0000_0000, 64'h0, TIMEOUT - 1, 16'h5A5A);
        // byte write by writeback
        do_access(4'b0001, 4'b0001, 4'b0001, 64'h0000_0000_0000_0400, 64'h0000_0000_0000_00CD, 2, 16'h0);

        // reset during a fetch in flight
        req = 4'b1000; req_we = '0; req_byte = '0; req_addr = 64'h0600_0000_0000_0000;
        @(posedge clk); #1;
        check("rst_grant_pre", {28'd0, grant}, 32'd8);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_async", {22'd0, mem_en, grant, busy, done}, 32'd0);
        starve = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        do_access(4'b1000, 4'b0000, 4'b0000, 64'h0600_0000_0000_0000, 64'h0, 0, 16'hC0DE);

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            ra = {$urandom, $urandom};
            rw = {$urandom, $urandom};
            do_access(4'($urandom), 4'($urandom), 4'($urandom), ra, rw,
                      int'($urandom_range(0, TIMEOUT + 2)), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
